exe_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline, the consumer of the ID→EXE pipeline register. It takes the registered operands, immediate, shift amount, operand-select controls and 4-bit ALU operation, and selects the ALU inputs. Single-cycle ALU operations complete in one cycle. Multiply, divide and remainder run on an iterative 32-cycle shift/add–subtract datapath, and the stage raises `stall` to hold the upstream pipeline until they finish. Results are registered toward the EXE→MEM boundary with a one-cycle `result_valid` strobe.

---
 rtl/exe_stage_if.sv | 27 ++
 rtl/exe_stage.sv | 154 +++++++++++++++
 tb/tb_exe_stage.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// ID->EXE operand/control bundle plus the EXE->MEM result strobe.
// Signal names follow the pipeline register fields of the MIPS core.
interface exe_stage_if;
  logic        in_valid;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] inst_extended;
  logic [4:0]  shamnt;
  logic        AluSrc1;
  logic        AluSrc;
  logic [3:0]  AluOperation;
  logic        stall;
  logic [31:0] result;
  logic        result_valid;

  modport master (
    output in_valid, read_data1, read_data2, inst_extended, shamnt, AluSrc1, AluSrc,
           AluOperation,
    input  stall, result, result_valid
  );

  modport slave (
    input  in_valid, read_data1, read_data2, inst_extended, shamnt, AluSrc1, AluSrc,
           AluOperation,
    output stall, result, result_valid
  );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: single-cycle ALU plus a 32-iteration shift/add multiplier and
// restoring unsigned divider that stalls the upstream pipeline while it runs.
module exe_stage (
  input logic       clk,
  input logic       rst,
  exe_stage_if.slave bus
);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpNor   = 4'd5;
  localparam logic [3:0] OpSlt   = 4'd6;
  localparam logic [3:0] OpSltu  = 4'd7;
  localparam logic [3:0] OpSll   = 4'd8;
  localparam logic [3:0] OpSrl   = 4'd9;
  localparam logic [3:0] OpSra   = 4'd10;
  localparam logic [3:0] OpLui   = 4'd11;
  localparam logic [3:0] OpMul   = 4'd12;
  localparam logic [3:0] OpDivu  = 4'd13;
  localparam logic [3:0] OpRemu  = 4'd14;
  localparam logic [3:0] OpPassb = 4'd15;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;
  logic        neg_q;
  // MUL: acc = partial product, x = shifting |A|, y = shifting |B|.
  // DIV: acc = partial remainder, x = dividend/quotient, y = divisor.
  logic [31:0] acc_q, x_q, y_q;
  logic [31:0] result_q;
  logic        result_valid_q;

  logic [31:0] op_a, op_b, alu_res;
  logic [31:0] a_abs, b_abs;
  logic        is_multi;
  logic [32:0] div_shift, div_diff;
  logic [31:0] acc_n, x_n, y_n;
  logic [31:0] mul_fin, final_res;

  assign op_a  = bus.AluSrc1 ? {27'b0, bus.shamnt} : bus.read_data1;
  assign op_b  = bus.AluSrc ? bus.inst_extended : bus.read_data2;
  assign a_abs = op_a[31] ? -op_a : op_a;
  assign b_abs = op_b[31] ? -op_b : op_b;

  assign is_multi = (bus.AluOperation == OpMul) || (bus.AluOperation == OpDivu) ||
                    (bus.AluOperation == OpRemu);

  always_comb begin
    alu_res = '0;
    case (bus.AluOperation)
      OpAdd:   alu_res = op_a + op_b;
      OpSub:   alu_res = op_a - op_b;
      OpAnd:   alu_res = op_a & op_b;
      OpOr:    alu_res = op_a | op_b;
      OpXor:   alu_res = op_a ^ op_b;
      OpNor:   alu_res = ~(op_a | op_b);
      OpSlt:   alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      OpSltu:  alu_res = {31'b0, op_a < op_b};
      OpSll:   alu_res = op_b << op_a[4:0];
      OpSrl:   alu_res = op_b >> op_a[4:0];
      OpSra:   alu_res = $unsigned($signed(op_b) >>> op_a[4:0]);
      OpLui:   alu_res = {op_b[15:0], 16'h0};
      OpPassb: alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  // Borrow out of the 33-bit subtract means the shifted remainder is below the divisor.
  assign div_shift = {acc_q, x_q[31]};
  assign div_diff  = div_shift - {1'b0, y_q};

  always_comb begin
    acc_n = acc_q;
    x_n   = x_q;
    y_n   = y_q;
    if (op_q == OpMul) begin
      if (y_q[0]) acc_n = acc_q + x_q;
      x_n = x_q << 1;
      y_n = y_q >> 1;
    end else if (!div_diff[32]) begin
      acc_n = div_diff[31:0];
      x_n   = {x_q[30:0], 1'b1};
    end else begin
      acc_n = div_shift[31:0];
      x_n   = {x_q[30:0], 1'b0};
    end
  end

  assign mul_fin = neg_q ? -acc_n : acc_n;

  always_comb begin
    case (op_q)
      OpMul:   final_res = mul_fin;
      OpDivu:  final_res = x_n;
      default: final_res = acc_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      op_q           <= '0;
      neg_q          <= 1'b0;
      acc_q          <= '0;
      x_q            <= '0;
      y_q            <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            if (is_multi) begin
              op_q    <= bus.AluOperation;
              cnt_q   <= '0;
              acc_q   <= '0;
              neg_q   <= op_a[31] ^ op_b[31];
              x_q     <= (bus.AluOperation == OpMul) ? a_abs : op_a;
              y_q     <= (bus.AluOperation == OpMul) ? b_abs : op_b;
              state_q <= StBusy;
            end else begin
              result_q       <= alu_res;
              result_valid_q <= 1'b1;
            end
          end
        end
        StBusy: begin
          acc_q <= acc_n;
          x_q   <= x_n;
          y_q   <= y_n;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_q       <= final_res;
            result_valid_q <= 1'b1;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.stall        = (state_q == StBusy);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage with hand-computed expected values.
module tb_exe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exe_stage_if bus ();

  exe_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic [4:0] sh, input logic src1,
                       input logic src);
    bus.in_valid      = 1'b1;
    bus.AluOperation  = op;
    bus.read_data1    = d1;
    bus.read_data2    = d2;
    bus.inst_extended = imm;
    bus.shamnt        = sh;
    bus.AluSrc1       = src1;
    bus.AluSrc        = src;
  endtask

  task automatic rr_op(input string tag, input logic [3:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] exp);
    drive(op, d1, d2, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    chk({tag, "_res"}, bus.result, exp);
    chk({tag, "_rv"}, {31'b0, bus.result_valid}, 32'd1);
  endtask

  // Call right after the accepting edge; counts stall cycles up to a bound.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int n = 0;
    while (bus.stall === 1'b1 && n < 40) begin
      chk({tag, "_rv_busy"}, {31'b0, bus.result_valid}, 32'd0);
      n++;
      tick();
    end
    chk({tag, "_stall_cycles"}, n, 32'd32);
    chk({tag, "_rv"}, {31'b0, bus.result_valid}, 32'd1);
    chk({tag, "_res"}, bus.result, exp);
  endtask

  task automatic multi(input string tag, input logic [3:0] op, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] exp);
    rr_dummy_drive(op, d1, d2);
    tick();
    bus.in_valid = 1'b0;
    wait_done(tag, exp);
    tick();
    chk({tag, "_single_strobe"}, {31'b0, bus.result_valid}, 32'd0);
  endtask

  task automatic rr_dummy_drive(input logic [3:0] op, input logic [31:0] d1,
                                input logic [31:0] d2);
    drive(op, d1, d2, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("rst_result", bus.result, 32'h0);
    chk("rst_rv", {31'b0, bus.result_valid}, 32'd0);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    rst = 1'b0;

    rr_op("add", 4'd0, 32'd5, 32'd7, 32'd12);
    chk("add_stall", {31'b0, bus.stall}, 32'd0);

    drive(4'd8, 32'h0, 32'h0, 32'h1, 5'd4, 1'b1, 1'b1);
    tick();
    chk("sll_res", bus.result, 32'h10);
    chk("sll_rv_back2back", {31'b0, bus.result_valid}, 32'd1);

    drive(4'd10, 32'h0, 32'h0, 32'h8000_0000, 5'd31, 1'b1, 1'b1);
    tick();
    chk("sra_res", bus.result, 32'hFFFF_FFFF);

    drive(4'd9, 32'h0, 32'h0, 32'h8000_0000, 5'd4, 1'b1, 1'b1);
    tick();
    chk("srl_res", bus.result, 32'h0800_0000);

    drive(4'd11, 32'h0, 32'h0, 32'h0000_1234, 5'd0, 1'b0, 1'b1);
    tick();
    chk("lui_res", bus.result, 32'h1234_0000);

    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bubble_res", bus.result, 32'h1234_0000);
      chk("bubble_rv", {31'b0, bus.result_valid}, 32'd0);
    end

    rr_op("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
    rr_op("and", 4'd2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    rr_op("or", 4'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    rr_op("xor", 4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    rr_op("nor", 4'd5, 32'h0000_F0F0, 32'h0000_FF00, 32'hFFFF_000F);
    rr_op("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1);
    rr_op("sltu", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0);
    rr_op("passb", 4'd15, 32'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // MUL with an ADD held upstream during the stall.
    drive(4'd12, 32'hFFFF_FFFD, 32'd7, 32'h0, 5'd0, 1'b0, 1'b0);
    tick();
    drive(4'd0, 32'd1, 32'd2, 32'h0, 5'd0, 1'b0, 1'b0);
    wait_done("mul_neg", 32'hFFFF_FFEB);
    tick();
    chk("held_add_res", bus.result, 32'd3);
    chk("held_add_rv", {31'b0, bus.result_valid}, 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("held_add_once", {31'b0, bus.result_valid}, 32'd0);

    multi("mul_negneg", 4'd12, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'd30);
    multi("divu", 4'd13, 32'd100, 32'd7, 32'd14);
    multi("remu", 4'd14, 32'd100, 32'd7, 32'd2);
    multi("divu_zero", 4'd13, 32'd9, 32'd0, 32'hFFFF_FFFF);
    multi("remu_zero", 4'd14, 32'd9, 32'd0, 32'd9);

    // Reset during the 10th BUSY cycle of a DIVU.
    rr_dummy_drive(4'd13, 32'd100, 32'd7);
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk("midbusy_stall_before", {31'b0, bus.stall}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midbusy_stall", {31'b0, bus.stall}, 32'd0);
    chk("midbusy_res", bus.result, 32'h0);
    chk("midbusy_rv", {31'b0, bus.result_valid}, 32'd0);
    tick();
    chk("midbusy_rv_after", {31'b0, bus.result_valid}, 32'd0);
    chk("midbusy_stall_after", {31'b0, bus.stall}, 32'd0);
    rr_op("add_after_rst", 4'd0, 32'd5, 32'd7, 32'd12);

    // Reset together with a valid instruction drops it.
    drive(4'd0, 32'd20, 32'd22, 32'h0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_valid_res", bus.result, 32'h0);
    chk("rst_valid_rv", {31'b0, bus.result_valid}, 32'd0);
    tick();
    chk("rst_valid_rv_after", {31'b0, bus.result_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
